// File: rtl/jtcop_bgrom_arb.sv
// Arbitrates one SDRAM read slot among three BAC06 tile-ROM requesters.
// Each requester keeps a one-entry tag+data buffer for its last fetched word.
module jtcop_bgrom_arb #(
  parameter int unsigned AW = 17,
  parameter int unsigned SW = 22,
  parameter logic [SW-1:0] BA0_OFFSET = 22'h00000,
  parameter logic [SW-1:0] BA1_OFFSET = 22'h20000,
  parameter logic [SW-1:0] BA2_OFFSET = 22'h40000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          b0_cs,
  input  logic [AW-1:0] b0_addr,
  output logic [31:0]   b0_data,
  output logic          b0_ok,
  input  logic          b1_cs,
  input  logic [AW-1:0] b1_addr,
  output logic [31:0]   b1_data,
  output logic          b1_ok,
  input  logic          b2_cs,
  input  logic [AW-1:0] b2_addr,
  output logic [31:0]   b2_data,
  output logic          b2_ok,
  output logic          sdram_cs,
  output logic [SW-1:0] sdram_addr,
  input  logic [31:0]   sdram_data,
  input  logic          sdram_ok
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP
  } state_t;

  state_t        st;
  logic [1:0]    ptr;
  logic [1:0]    gnt;
  logic [AW-1:0] gaddr;
  logic [1:0]    pick;

  logic [2:0]    cs;
  logic [AW-1:0] addr [3];
  logic [2:0]    vld;
  logic [AW-1:0] tag  [3];
  logic [31:0]   dat  [3];
  logic [2:0]    hit;
  logic [2:0]    pend;
  logic [2:0]    ok;

  assign cs      = {b2_cs, b1_cs, b0_cs};
  assign addr[0] = b0_addr;
  assign addr[1] = b1_addr;
  assign addr[2] = b2_addr;

  assign b0_data = dat[0];
  assign b1_data = dat[1];
  assign b2_data = dat[2];
  assign b0_ok   = ok[0];
  assign b1_ok   = ok[1];
  assign b2_ok   = ok[2];

  function automatic logic [SW-1:0] base(input logic [1:0] n);
    unique case (n)
      2'd1:    return BA1_OFFSET;
      2'd2:    return BA2_OFFSET;
      default: return BA0_OFFSET;
    endcase
  endfunction

  function automatic logic [1:0] rr(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit[i]  = vld[i] && (tag[i] == addr[i]);
      pend[i] = cs[i] && !hit[i];
    end
  end

  // scan from the farthest candidate back so the nearest pending one wins
  always_comb begin
    pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      if (pend[rr(ptr, k)]) pick = rr(ptr, k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 2'd0;
      gaddr      <= '0;
      sdram_cs   <= 1'b0;
      sdram_addr <= '0;
      vld        <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        tag[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      unique case (st)
        IDLE: begin
          if (|pend) begin
            gnt        <= pick;
            gaddr      <= addr[pick];
            sdram_addr <= SW'(addr[pick]) + base(pick);
            sdram_cs   <= 1'b1;
            st         <= WAIT;
          end
        end
        WAIT: begin
          if (sdram_ok) begin
            vld[gnt]  <= 1'b1;
            tag[gnt]  <= gaddr;
            dat[gnt]  <= sdram_data;
            sdram_cs  <= 1'b0;
            ptr       <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
            st        <= GAP;
          end
        end
        GAP: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ok <= 3'b000;
    else     ok <= cs & hit;
  end

endmodule

// File: tb/tb_jtcop_bgrom_arb.sv
// Bench for jtcop_bgrom_arb: SDRAM model with fixed latency,
// request-address scoreboard and buffered-data monitor.
module tb_jtcop_bgrom_arb;

  localparam int LAT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       bcs = 3'b000;
  logic [2:0][16:0] badr = '0;
  logic [2:0][31:0] bdat;
  logic [2:0]       bok;
  logic             sdram_cs;
  logic [21:0]      sdram_addr;
  logic [31:0]      sdram_data;
  logic             sdram_ok;
  logic             mok = 1'b0;
  logic             inj = 1'b0;
  int               cnt = 0;

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;

  logic [21:0]      exp_q [$];
  logic             p_cs = 1'b0;
  logic [21:0]      p_saddr = '0;
  logic [2:0][16:0] p_adr = '0;

  always #5 clk = ~clk;

  jtcop_bgrom_arb dut (
    .clk        (clk),
    .rst        (rst),
    .b0_cs      (bcs[0]),
    .b0_addr    (badr[0]),
    .b0_data    (bdat[0]),
    .b0_ok      (bok[0]),
    .b1_cs      (bcs[1]),
    .b1_addr    (badr[1]),
    .b1_data    (bdat[1]),
    .b1_ok      (bok[1]),
    .b2_cs      (bcs[2]),
    .b2_addr    (badr[2]),
    .b2_data    (bdat[2]),
    .b2_ok      (bok[2]),
    .sdram_cs   (sdram_cs),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_ok   (sdram_ok)
  );

  function automatic logic [31:0] mdata(input logic [21:0] a);
    return {a[9:0], a} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [21:0] saddr(input int n, input logic [16:0] a);
    logic [21:0] off;
    off = (n == 0) ? 22'h00000 : (n == 1) ? 22'h20000 : 22'h40000;
    return {5'd0, a} + off;
  endfunction

  // SDRAM model: ok in the LAT-th cycle of a request
  always @(posedge clk) begin
    if (!sdram_cs) begin
      cnt <= 0;
      mok <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      mok <= (cnt == LAT - 2);
    end
  end
  assign sdram_ok   = mok | inj;
  assign sdram_data = mdata(sdram_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sdram_cs && !p_cs) begin
      n_req++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_req: got %h want none", sdram_addr);
      end else begin
        chk("req_addr", {10'd0, sdram_addr}, {10'd0, exp_q.pop_front()});
      end
    end else if (sdram_cs && p_cs) begin
      chk("addr_hold", {10'd0, sdram_addr}, {10'd0, p_saddr});
    end
    for (int n = 0; n < 3; n++)
      if (bok[n]) chk("ok_data", bdat[n], mdata(saddr(n, p_adr[n])));
    p_cs    = sdram_cs;
    p_saddr = sdram_addr;
    p_adr   = badr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_ok(input int n, input string nm, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bok[n]) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no ok want ok", nm);
    end
  endtask

  task automatic wait_cs(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = sdram_cs;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no sdram_cs want cs", nm);
    end
  endtask

  task automatic fetch0(input logic [16:0] a);
    int c;
    badr[0] = a;
    exp_q.push_back(saddr(0, a));
    wait_ok(0, "toggle", c);
    chk("toggle_data", bdat[0], mdata(saddr(0, a)));
  endtask

  initial begin
    int c;
    int r0;
    int okc;
    int rnd [3];
    bit done;

    do_reset();
    chk("rst_sdram_cs", {31'd0, sdram_cs}, 32'd0);
    chk("rst_sdram_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_ok", {29'd0, bok}, 32'd0);
    for (int n = 0; n < 3; n++) chk("rst_data", bdat[n], 32'd0);

    // single miss, latency check
    bcs[0]  = 1'b1;
    badr[0] = 17'h00010;
    exp_q.push_back(22'h00010);
    wait_ok(0, "b0_first", c);
    chk("b0_latency", c, 6);
    chk("b0_data", bdat[0], mdata(22'h00010));

    // layer 1 offset and stable-address hold
    bcs[0]  = 1'b0;
    bcs[1]  = 1'b1;
    badr[1] = 17'h00003;
    exp_q.push_back(22'h20003);
    wait_ok(1, "b1_first", c);
    chk("b1_data", bdat[1], mdata(22'h20003));
    r0  = n_req;
    okc = 0;
    repeat (20) begin
      tick();
      okc += int'(bok[1]);
    end
    chk("b1_hold_ok", okc, 20);
    chk("b1_no_req", n_req - r0, 0);

    // fairness with all three requesting
    bcs = 3'b000;
    tick();
    do_reset();
    badr[0] = 17'h00100;
    badr[1] = 17'h00200;
    badr[2] = 17'h00300;
    exp_q.push_back(22'h00100);
    exp_q.push_back(22'h20200);
    exp_q.push_back(22'h40300);
    exp_q.push_back(22'h00101);
    exp_q.push_back(22'h20201);
    exp_q.push_back(22'h40301);
    bcs  = 3'b111;
    rnd  = '{0, 0, 0};
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      for (int n = 0; n < 3; n++) begin
        if (bok[n] && rnd[n] < 2) begin
          rnd[n]++;
          if (rnd[n] < 2) badr[n] = badr[n] + 17'd1;
        end
      end
      done = (rnd[0] == 2) && (rnd[1] == 2) && (rnd[2] == 2);
    end
    for (int n = 0; n < 3; n++) chk("rr_rounds", rnd[n], 2);
    chk("rr_queue_empty", exp_q.size(), 0);

    // b2 changes address while its fetch is in flight
    bcs = 3'b000;
    repeat (3) tick();
    badr[2] = 17'h00005;
    bcs[2]  = 1'b1;
    exp_q.push_back(22'h40005);
    wait_cs("b2_req");
    tick();
    badr[2] = 17'h00006;
    exp_q.push_back(22'h40006);
    wait_ok(2, "b2_new", c);
    chk("b2_data", bdat[2], mdata(22'h40006));
    chk("b2_two_req", exp_q.size(), 0);

    // reset while waiting on SDRAM
    bcs[2]  = 1'b0;
    badr[1] = 17'h00201;
    bcs[1]  = 1'b1;
    badr[0] = 17'h00050;
    bcs[0]  = 1'b1;
    exp_q.push_back(22'h00050);
    wait_cs("b0_req");
    chk("b1_hit_pre_rst", {31'd0, bok[1]}, 32'd1);
    tick();
    rst = 1'b1;
    exp_q.push_back(22'h00050);
    exp_q.push_back(22'h20201);
    tick();
    rst = 1'b0;
    inj = 1'b1;
    chk("mid_rst_cs", {31'd0, sdram_cs}, 32'd0);
    chk("mid_rst_ok", {29'd0, bok}, 32'd0);
    tick();
    inj = 1'b0;
    wait_ok(0, "b0_after_rst", c);
    chk("b0_rst_data", bdat[0], mdata(22'h00050));
    wait_ok(1, "b1_after_rst", c);
    chk("b1_rst_data", bdat[1], mdata(22'h20201));

    // toggling between two addresses refetches each time
    bcs[1] = 1'b0;
    fetch0(17'h00051);
    fetch0(17'h00050);
    fetch0(17'h00051);
    fetch0(17'h00050);

    bcs = 3'b000;
    repeat (10) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
